// File: rtl/fatori_err_pkg.sv
// Shared types and helpers for the fault-event collector: event type encoding,
// output slot state, saturating add and popcount.
package fatori_err_pkg;

  typedef enum logic [1:0] {
    EVT_MAJ   = 2'd0,
    EVT_MIN   = 2'd1,
    EVT_SCRUB = 2'd2,
    EVT_RSVD  = 2'd3
  } evt_type_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam int unsigned NUM_TYPES = 3;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) begin
      return max_v;
    end else begin
      return sum[31:0];
    end
  endfunction

  function automatic logic [6:0] popcount64(input logic [63:0] v);
    logic [6:0] n;
    n = 7'd0;
    for (int i = 0; i < 64; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/fatori_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i,
// searching upwards and wrapping at NUM_SRC-1.
module fatori_rr_arbiter #(
  parameter int NUM_SRC = 8,
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               grant_valid_o,
  output logic [ID_W-1:0]    grant_idx_o
);

  // Scan offsets from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    int idx;
    logic [ID_W-1:0] sel;
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    idx           = 0;
    sel           = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_SRC) begin
        idx = idx - NUM_SRC;
      end else begin
        idx = idx;
      end
      sel = idx[ID_W-1:0];
      if (req_i[sel]) begin
        grant_valid_o = 1'b1;
        grant_idx_o   = sel;
      end else begin
        grant_valid_o = grant_valid_o;
      end
    end
  end

endmodule

// File: rtl/fatori_err_collector.sv
// Collects major/minor/scrub fault pulses per source, counts them, and serializes
// pending events onto one valid/ready stream with round-robin source fairness.
module fatori_err_collector
  import fatori_err_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 16,
  localparam int ID_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               clr_i,
  input  logic [NUM_SRC-1:0] new_maj_err_i,
  input  logic [NUM_SRC-1:0] new_min_err_i,
  input  logic [NUM_SRC-1:0] scrub_i,
  output logic               evt_valid_o,
  input  logic               evt_ready_i,
  output logic [ID_W-1:0]    evt_src_o,
  output logic [1:0]         evt_type_o,
  output logic [CNT_W-1:0]   maj_cnt_o,
  output logic [CNT_W-1:0]   min_cnt_o,
  output logic [CNT_W-1:0]   scrub_cnt_o,
  output logic               ovf_o
);

  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  logic [2:0][NUM_SRC-1:0] pend_q, pend_d, pulse_s;
  slot_state_e             state_q, state_d;
  logic [ID_W-1:0]         src_q, src_d, ptr_q, ptr_d, grant_idx_s;
  evt_type_e               type_q, type_d, grant_type_s;
  logic [CNT_W-1:0]        maj_cnt_q, maj_cnt_d, min_cnt_q, min_cnt_d, scr_cnt_q, scr_cnt_d;
  logic                    ovf_q, ovf_d;
  logic [NUM_SRC-1:0]      req_s;
  logic                    grant_valid_s, load_s;

  assign pulse_s = {scrub_i, new_min_err_i, new_maj_err_i};
  assign req_s   = pend_q[0] | pend_q[1] | pend_q[2];
  assign load_s  = grant_valid_s & ((state_q == SLOT_EMPTY) | evt_ready_i);

  fatori_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req_i        (req_s),
    .ptr_i        (ptr_q),
    .grant_valid_o(grant_valid_s),
    .grant_idx_o  (grant_idx_s)
  );

  // Type priority within the granted source: MAJ, then MIN, then SCRUB.
  always_comb begin
    grant_type_s = EVT_SCRUB;
    if (pend_q[0][grant_idx_s]) begin
      grant_type_s = EVT_MAJ;
    end else if (pend_q[1][grant_idx_s]) begin
      grant_type_s = EVT_MIN;
    end else begin
      grant_type_s = EVT_SCRUB;
    end
  end

  // Next-state: counters, slot load/drain, pending store and overflow tracking.
  always_comb begin
    pend_d    = pend_q;
    state_d   = state_q;
    src_d     = src_q;
    type_d    = type_q;
    ptr_d     = ptr_q;
    maj_cnt_d = maj_cnt_q;
    min_cnt_d = min_cnt_q;
    scr_cnt_d = scr_cnt_q;
    ovf_d     = ovf_q;
    if (clr_i) begin
      pend_d    = '0;
      state_d   = SLOT_EMPTY;
      src_d     = '0;
      type_d    = EVT_MAJ;
      ptr_d     = '0;
      maj_cnt_d = '0;
      min_cnt_d = '0;
      scr_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      maj_cnt_d = CNT_W'(sat_add(32'(maj_cnt_q), 32'(popcount64(64'(new_maj_err_i))), CNT_MAX));
      min_cnt_d = CNT_W'(sat_add(32'(min_cnt_q), 32'(popcount64(64'(new_min_err_i))), CNT_MAX));
      scr_cnt_d = CNT_W'(sat_add(32'(scr_cnt_q), 32'(popcount64(64'(scrub_i))), CNT_MAX));
      if (load_s) begin
        pend_d[grant_type_s][grant_idx_s] = 1'b0;
        state_d = SLOT_FULL;
        src_d   = grant_idx_s;
        type_d  = grant_type_s;
        ptr_d   = (grant_idx_s == ID_W'(NUM_SRC - 1)) ? '0 : grant_idx_s + ID_W'(1);
      end else if ((state_q == SLOT_FULL) && evt_ready_i) begin
        state_d = SLOT_EMPTY;
      end else begin
        state_d = state_q;
      end
      // pend_d already reflects this cycle's consume, so a still-set bit means a lost pulse.
      for (int t = 0; t < 3; t++) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (pulse_s[t][s]) begin
            if (pend_d[t][s]) begin
              ovf_d = 1'b1;
            end else begin
              ovf_d = ovf_d;
            end
            pend_d[t][s] = 1'b1;
          end else begin
            pend_d[t][s] = pend_d[t][s];
          end
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      pend_q    <= '0;
      state_q   <= SLOT_EMPTY;
      src_q     <= '0;
      type_q    <= EVT_MAJ;
      ptr_q     <= '0;
      maj_cnt_q <= '0;
      min_cnt_q <= '0;
      scr_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      state_q   <= state_d;
      src_q     <= src_d;
      type_q    <= type_d;
      ptr_q     <= ptr_d;
      maj_cnt_q <= maj_cnt_d;
      min_cnt_q <= min_cnt_d;
      scr_cnt_q <= scr_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign evt_valid_o = (state_q == SLOT_FULL);
  assign evt_src_o   = src_q;
  assign evt_type_o  = type_q;
  assign maj_cnt_o   = maj_cnt_q;
  assign min_cnt_o   = min_cnt_q;
  assign scrub_cnt_o = scr_cnt_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fatori_err_collector.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_fatori_err_collector;

  localparam int NUM_SRC = 8;
  localparam int CNT_W   = 4;
  localparam int ID_W    = 3;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               arst, clr, ready;
  logic [NUM_SRC-1:0] maj, mnr, scr;
  logic               evt_valid_o;
  logic [ID_W-1:0]    evt_src_o;
  logic [1:0]         evt_type_o;
  logic [CNT_W-1:0]   maj_cnt_o, min_cnt_o, scrub_cnt_o;
  logic               ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  fatori_err_collector #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .clr_i        (clr),
    .new_maj_err_i(maj),
    .new_min_err_i(mnr),
    .scrub_i      (scr),
    .evt_valid_o  (evt_valid_o),
    .evt_ready_i  (ready),
    .evt_src_o    (evt_src_o),
    .evt_type_o   (evt_type_o),
    .maj_cnt_o    (maj_cnt_o),
    .min_cnt_o    (min_cnt_o),
    .scrub_cnt_o  (scrub_cnt_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending events as a table, slot as a record, plain integer counters.
  bit m_pend [3][NUM_SRC];
  int m_cnt  [3];
  bit m_valid, m_ovf;
  int m_src, m_type, m_ptr;

  task automatic m_reset();
    for (int t = 0; t < 3; t++) begin
      m_cnt[t] = 0;
      for (int s = 0; s < NUM_SRC; s++) m_pend[t][s] = 1'b0;
    end
    m_valid = 1'b0; m_ovf = 1'b0; m_src = 0; m_type = 0; m_ptr = 0;
  endtask

  task automatic m_step();
    logic [NUM_SRC-1:0] pv [3];
    int g;
    pv[0] = maj; pv[1] = mnr; pv[2] = scr;
    if (clr) begin
      m_reset();
    end else begin
      for (int t = 0; t < 3; t++) begin
        m_cnt[t] = m_cnt[t] + $countones(pv[t]);
        if (m_cnt[t] > CMAX) m_cnt[t] = CMAX;
      end
      if (!m_valid || ready) begin
        m_valid = 1'b0;
        g = -1;
        for (int k = 0; k < NUM_SRC; k++) begin
          int s;
          s = (m_ptr + k) % NUM_SRC;
          if (g < 0 && (m_pend[0][s] || m_pend[1][s] || m_pend[2][s])) g = s;
        end
        if (g >= 0) begin
          m_type = m_pend[0][g] ? 0 : (m_pend[1][g] ? 1 : 2);
          m_pend[m_type][g] = 1'b0;
          m_valid = 1'b1;
          m_src = g;
          m_ptr = (g + 1) % NUM_SRC;
        end
      end
      for (int t = 0; t < 3; t++)
        for (int s = 0; s < NUM_SRC; s++)
          if (pv[t][s]) begin
            if (m_pend[t][s]) m_ovf = 1'b1;
            m_pend[t][s] = 1'b1;
          end
    end
  endtask

  always @(posedge clk or posedge arst) begin
    if (arst) m_reset();
    else m_step();
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!arst) begin
      chk("valid", evt_valid_o, m_valid);
      if (m_valid) begin
        chk("src", evt_src_o, m_src);
        chk("type", evt_type_o, m_type);
      end
      chk("maj_cnt", maj_cnt_o, m_cnt[0]);
      chk("min_cnt", min_cnt_o, m_cnt[1]);
      chk("scrub_cnt", scrub_cnt_o, m_cnt[2]);
      chk("ovf", ovf_o, m_ovf);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic no_pulse();
    maj = '0; mnr = '0; scr = '0;
  endtask

  task automatic do_clr();
    cyc(); clr = 1'b1; no_pulse();
    cyc(); clr = 1'b0;
  endtask

  initial begin
    arst = 1'b1; clr = 1'b0; ready = 1'b0; no_pulse();
    #2;
    chk("rst_valid", evt_valid_o, 32'd0);
    chk("rst_src", evt_src_o, 32'd0);
    chk("rst_type", evt_type_o, 32'd0);
    chk("rst_maj", maj_cnt_o, 32'd0);
    chk("rst_ovf", ovf_o, 32'd0);
    cyc(); arst = 1'b0;

    // Single MAJ on src 3: two-cycle latency.
    do_clr(); ready = 1'b1; maj = 8'h08;
    cyc(); no_pulse(); chk("t1_lat_valid", evt_valid_o, 32'd0);
    cyc();
    chk("t1_valid", evt_valid_o, 32'd1);
    chk("t1_src", evt_src_o, 32'd3);
    chk("t1_type", evt_type_o, 32'd0);
    chk("t1_maj", maj_cnt_o, 32'd1);
    chk("t1_ovf", ovf_o, 32'd0);
    cyc(); chk("t1_drain", evt_valid_o, 32'd0);

    // MIN on src 0, 2, 5 together.
    do_clr(); ready = 1'b1; mnr = 8'b0010_0101;
    cyc(); no_pulse();
    cyc(); chk("t2_src_a", evt_src_o, 32'd0); chk("t2_type", evt_type_o, 32'd1);
    cyc(); chk("t2_src_b", evt_src_o, 32'd2);
    cyc(); chk("t2_src_c", evt_src_o, 32'd5); chk("t2_cnt", min_cnt_o, 32'd3);
    cyc(); chk("t2_drain", evt_valid_o, 32'd0);

    // All three types on src 1: MAJ, MIN, SCRUB order.
    do_clr(); ready = 1'b1; maj = 8'h02; mnr = 8'h02; scr = 8'h02;
    cyc(); no_pulse();
    cyc(); chk("t3_type_a", evt_type_o, 32'd0); chk("t3_src", evt_src_o, 32'd1);
    cyc(); chk("t3_type_b", evt_type_o, 32'd1);
    cyc(); chk("t3_type_c", evt_type_o, 32'd2);
    chk("t3_maj", maj_cnt_o, 32'd1); chk("t3_min", min_cnt_o, 32'd1); chk("t3_scr", scrub_cnt_o, 32'd1);

    // Back-pressure: third MAJ on src 4 finds its bit still pending.
    do_clr(); ready = 1'b0; maj = 8'h10;
    cyc(); no_pulse();
    cyc(); chk("t4_valid", evt_valid_o, 32'd1); chk("t4_src", evt_src_o, 32'd4);
    cyc(); cyc(); maj = 8'h10;
    cyc(); no_pulse();
    cyc(); cyc();
    chk("t4_no_ovf", ovf_o, 32'd0); maj = 8'h10;
    cyc(); no_pulse();
    chk("t4_ovf", ovf_o, 32'd1); chk("t4_hold_src", evt_src_o, 32'd4);
    chk("t4_hold_type", evt_type_o, 32'd0); chk("t4_maj", maj_cnt_o, 32'd3);
    ready = 1'b1;
    cyc(); chk("t4_next", evt_valid_o, 32'd1); chk("t4_next_src", evt_src_o, 32'd4);
    cyc(); chk("t4_drain", evt_valid_o, 32'd0); chk("t4_sticky", ovf_o, 32'd1);

    // Continuous MIN on all sources: saturation and rotation.
    do_clr(); ready = 1'b1; mnr = 8'hFF;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      if (i >= 2) chk("t5_rot", evt_src_o, i - 2);
    end
    chk("t5_sat", min_cnt_o, 32'd15);
    no_pulse();
    repeat (10) cyc();
    chk("t5_sat_hold", min_cnt_o, 32'd15);

    // Async reset while FULL with 5 pending, then restart from ptr 0.
    do_clr(); ready = 1'b0; maj = 8'hAF;
    cyc(); no_pulse();
    cyc(); chk("t6_full", evt_valid_o, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("t6_valid", evt_valid_o, 32'd0); chk("t6_maj", maj_cnt_o, 32'd0);
    chk("t6_src", evt_src_o, 32'd0); chk("t6_ovf", ovf_o, 32'd0);
    cyc(); arst = 1'b0; ready = 1'b1; maj = 8'h40;
    cyc(); no_pulse();
    cyc(); chk("t6_src6", evt_src_o, 32'd6); chk("t6_v", evt_valid_o, 32'd1);
    cyc(); chk("t6_drain", evt_valid_o, 32'd0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      maj = NUM_SRC'($urandom & $urandom & $urandom);
      mnr = NUM_SRC'($urandom & $urandom & $urandom);
      scr = NUM_SRC'($urandom & $urandom & $urandom & $urandom);
      ready = (i % 500 < 100) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 79) == 0);
    end
    cyc(); no_pulse(); clr = 1'b0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
